bcd_countdown_99: RTL

- Two-digit BCD down-counter and timer, 99..00. It is the counting-down counterpart of the team's cascaded decade up-counters.
- Loaded with a BCD preset, then started. It decrements once every TICK_DIV clocks and pulses done on reaching 00.
- Fully synchronous: one clock plus a tick enable, no ripple or derived clocks.
- Feeds display and sequencing logic that needs a settable countdown.

---
 rtl/bcd_countdown_99_pkg.sv | 9 +
 rtl/bcd_digit_down.sv | 18 +
 rtl/bcd_countdown_99.sv | 69 ++++++
 3 files changed

// File: rtl/bcd_countdown_99_pkg.sv
// bcd_countdown_99_pkg: shared state encoding, BCD digit limits and the digit clamp helper
package bcd_countdown_99_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2} state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return d > BCD_MAX ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: one BCD decade down-counter with clamped load, dec_en and borrow_out (dec_en while at 0)
module bcd_digit_down
  import bcd_countdown_99_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  output logic [3:0] digit,
  output logic       borrow_out
);
  assign borrow_out = dec_en && digit == BCD_ZERO;
  always_ff @(posedge clk or negedge rst)
    if (!rst) digit <= BCD_ZERO;
    else if (load) digit <= clamp_digit(load_val);
    else if (dec_en) digit <= digit == BCD_ZERO ? BCD_MAX : digit - 4'd1;
endmodule

// File: rtl/bcd_countdown_99.sv
// bcd_countdown_99: two-digit BCD countdown timer (load/start/pause in, count/running/done out, async active-low rst)
module bcd_countdown_99
  import bcd_countdown_99_pkg::*;
#(
  parameter int TICK_DIV = 10,
  parameter int PRESC_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_low,
  input  logic [3:0] load_high,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] count_low,
  output logic [3:0] count_high,
  output logic       running,
  output logic       done
);
  state_t state, state_n;
  logic [PRESC_W-1:0] presc, presc_n;
  logic wrap, tick, last, nonzero, borrow_low, borrow_high, done_n;
  assign wrap = presc == PRESC_W'(TICK_DIV - 1);
  assign tick = state == RUN && wrap && !load && !pause;
  assign last = count_high == BCD_ZERO && count_low == 4'd1;
  assign nonzero = count_low != BCD_ZERO || count_high != BCD_ZERO;
  bcd_digit_down u_low (
    .clk(clk), .rst(rst), .load(load), .load_val(load_low),
    .dec_en(tick), .digit(count_low), .borrow_out(borrow_low)
  );
  bcd_digit_down u_high (
    .clk(clk), .rst(rst), .load(load), .load_val(load_high),
    .dec_en(borrow_low), .digit(count_high), .borrow_out(borrow_high)
  );
  always_comb begin
    state_n = state;
    presc_n = presc;
    done_n = 1'b0;
    if (load) begin
      state_n = IDLE;
      presc_n = '0;
    end else if (pause) begin
      if (state == RUN) state_n = PAUSED;
    end else if (state == RUN) begin
      presc_n = wrap ? '0 : presc + 1'b1;
      if (tick && (last || borrow_high)) begin
        state_n = IDLE;
        done_n = 1'b1;
      end
    end else if (start && state == PAUSED) begin
      state_n = RUN;
    end else if (start && state == IDLE && nonzero) begin
      state_n = RUN;
      presc_n = '0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      presc <= '0;
      running <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      running <= state_n == RUN;
      done <= done_n;
    end
endmodule
